// File: rtl/sipo_rr_arbiter.sv
// Round-robin arbiter that time-shares one serial-to-parallel converter among
// NUM_REQ serial requesters. Define SIPO_ARB_FIXED_PRIO_EN for fixed priority.
module sipo_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int FRAME_LEN = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   s_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 sipo_in_valid,
  output logic                 sipo_s_in,
  input  logic                 sipo_out_valid,
  input  logic [FRAME_LEN-1:0] sipo_p_out,
  output logic                 out_valid,
  output logic [FRAME_LEN-1:0] out_data,
  output logic [ID_W-1:0]      out_id,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]      sel_id_q, sel_id_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [FRAME_LEN-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]      out_id_q, out_id_d;
  logic                 err_q, err_d;
  logic [ID_W-1:0]      win_id;

`ifdef SIPO_ARB_FIXED_PRIO_EN
  // Lowest set index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_id = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            win_found;

  always_comb begin
    int idx;
    win_id    = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_id    = ID_W'(idx);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && |req) begin
      ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // out_valid is a one-cycle strobe with no back-pressure: the consumer must
  // take out_data/out_id in the cycle out_valid is high (they hold afterwards).
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_id_d    = sel_id_q;
    bit_cnt_d   = bit_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          sel_id_d  = win_id;
          bit_cnt_d = '0;
          state_d   = XFER;
        end
      end
      XFER: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          gnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (sipo_out_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = sipo_p_out;
          out_id_d    = sel_id_q;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_id_q    <= '0;
      bit_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_id_q    <= sel_id_d;
      bit_cnt_q   <= bit_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      err_q       <= err_d;
    end
  end

  // Bit is steered combinationally so it is consumed in the cycle its gnt is high.
  assign sipo_in_valid = (state_q == XFER);
  assign sipo_s_in     = (state_q == XFER) & s_data[sel_id_q];
  assign gnt           = gnt_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_id        = out_id_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sipo_rr_arbiter.sv
// Self-checking bench for sipo_rr_arbiter: a behavioural converter stub plus a
// scoreboard fed by a frame-level arbitration model.
module tb_sipo_rr_arbiter;

  localparam int N  = 4;
  localparam int FL = 4;
  localparam int IW = 2;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic [N-1:0]  req    = '0;
  logic [N-1:0]  s_data = '0;
  logic [N-1:0]  gnt;
  logic          sipo_in_valid, sipo_s_in;
  logic          out_valid, busy, err;
  logic [FL-1:0] out_data;
  logic [IW-1:0] out_id;
  logic [1:0]    dbg_state;

  logic [FL-1:0] stub_sh, stub_p;
  logic [1:0]    stub_cnt;
  logic          stub_ov;
  logic          stub_mute = 1'b0;

  int tests_run = 0;
  int fails     = 0;
  int mptr      = 0;
  logic [FL-1:0]    last_data = '0;
  logic [IW-1:0]    last_id   = '0;
  logic [FL-1:0]    words[N];
  logic [IW+FL-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sipo_rr_arbiter #(.NUM_REQ(N), .FRAME_LEN(FL), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .s_data(s_data), .gnt(gnt),
    .sipo_in_valid(sipo_in_valid), .sipo_s_in(sipo_s_in),
    .sipo_out_valid(stub_ov), .sipo_p_out(stub_p),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // Converter: shifts left, MSB first, answers one cycle after the last bit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_sh <= '0; stub_p <= '0; stub_cnt <= '0; stub_ov <= 1'b0;
    end else begin
      stub_ov <= 1'b0;
      if (sipo_in_valid) begin
        stub_sh <= {stub_sh[FL-2:0], sipo_s_in};
        if (stub_cnt == 2'd3) begin
          stub_cnt <= '0;
          stub_p   <= {stub_sh[FL-2:0], sipo_s_in};
          stub_ov  <= !stub_mute;
        end else begin
          stub_cnt <= stub_cnt + 2'd1;
        end
      end
    end
  end

  task automatic rand_words();
    for (int i = 0; i < N; i++) words[i] = FL'($urandom_range(0, 15));
  endtask

  // ---------------- driver: one full frame, entered and left in IDLE ----------------
  task automatic do_frame(input string name, input logic [N-1:0] pattern,
                          input logic [N-1:0] drop, input bit mute);
    int win;
    logic [N-1:0]     exp_gnt;
    logic [IW+FL-1:0] item;
    win = -1;
`ifdef SIPO_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (win < 0 && pattern[i]) win = i;
`else
    for (int i = 0; i < N; i++) if (win < 0 && pattern[(mptr + i) % N]) win = (mptr + i) % N;
    mptr = (win + 1) % N;
`endif
    exp_gnt = '0;
    exp_gnt[win] = 1'b1;
    exp_q.push_back({IW'(win), words[win]});
    stub_mute = mute;
    req = pattern;
    @(posedge clk); #1;
    for (int k = 0; k < FL; k++) begin
      for (int i = 0; i < N; i++) s_data[i] = words[i][FL-1-k];
      if (k == 2) req = pattern & ~drop;
      #1;
      tests_run++;
      if (gnt !== exp_gnt || sipo_in_valid !== 1'b1 || busy !== 1'b1 ||
          sipo_s_in !== words[win][FL-1-k] || out_valid !== 1'b0 || err !== 1'b0) begin
        fails++;
        $display("FAIL %s xfer%0d: gnt=%b in_valid=%b busy=%b s_in=%b ov=%b err=%b, required gnt=%b in_valid=1 busy=1 s_in=%b ov=0 err=0",
                 name, k, gnt, sipo_in_valid, busy, sipo_s_in, out_valid, err, exp_gnt, words[win][FL-1-k]);
      end
      @(posedge clk); #1;
    end
    s_data = N'($urandom_range(0, 15));
    #1;
    tests_run++;
    if (gnt !== '0 || sipo_in_valid !== 1'b0 || sipo_s_in !== 1'b0 || busy !== 1'b1 ||
        out_valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s wait: gnt=%b in_valid=%b s_in=%b busy=%b ov=%b err=%b, required 0 0 0 1 0 0",
               name, gnt, sipo_in_valid, sipo_s_in, busy, out_valid, err);
    end
    @(posedge clk); #1;
    item = exp_q.pop_front();
    tests_run++;
    if (!mute) begin
      if (out_valid !== 1'b1 || out_data !== item[FL-1:0] || out_id !== item[IW+FL-1:FL] ||
          err !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL %s result: ov=%b data=%b id=%0d err=%b busy=%b, required ov=1 data=%b id=%0d err=0 busy=0",
                 name, out_valid, out_data, out_id, err, busy, item[FL-1:0], item[IW+FL-1:FL]);
      end
      last_data = item[FL-1:0];
      last_id   = item[IW+FL-1:FL];
    end else begin
      if (out_valid !== 1'b0 || err !== 1'b1 || out_data !== last_data || out_id !== last_id ||
          busy !== 1'b0) begin
        fails++;
        $display("FAIL %s err_result: ov=%b err=%b data=%b id=%0d busy=%b, required ov=0 err=1 data=%b id=%0d busy=0",
                 name, out_valid, err, out_data, out_id, busy, last_data, last_id);
      end
    end
    req = '0;
    stub_mute = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; req = '0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (gnt !== '0 || sipo_in_valid !== 1'b0 || sipo_s_in !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== '0 || out_id !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset: gnt=%b iv=%b si=%b ov=%b data=%b id=%0d busy=%b err=%b, required all 0",
               gnt, sipo_in_valid, sipo_s_in, out_valid, out_data, out_id, busy, err);
    end
    rst_n = 1'b1;
    mptr = 0;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || gnt !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b gnt=%b, required busy=0 gnt=0", busy, gnt);
    end
  endtask

  task automatic test_basic();
    rand_words();
    words[1] = 4'b1011;
    do_frame("basic", 4'b0010, 4'b0000, 1'b0);
  endtask

  task automatic test_all_req();
    for (int f = 0; f < 8; f++) begin
      rand_words();
      do_frame("all_req", 4'b1111, 4'b0000, 1'b0);
    end
  endtask

  task automatic test_wrap();
    rand_words(); do_frame("wrap_pre", 4'b0001, 4'b0000, 1'b0);
    rand_words(); do_frame("wrap_a",   4'b1001, 4'b0000, 1'b0);
    rand_words(); do_frame("wrap_b",   4'b1001, 4'b0000, 1'b0);
  endtask

  task automatic test_drop();
    rand_words();
    do_frame("drop", 4'b0100, 4'b0100, 1'b0);
  endtask

  task automatic test_err();
    rand_words();
    do_frame("err", 4'b0110, 4'b0000, 1'b1);
    rand_words();
    do_frame("after_err", 4'b1000, 4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid();
    int bad;
    rand_words();
    req = 4'b1000;
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (gnt !== '0 || sipo_in_valid !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== '0 || out_id !== '0) begin
      fails++;
      $display("FAIL reset_mid: gnt=%b iv=%b busy=%b ov=%b data=%b id=%0d, required all 0",
               gnt, sipo_in_valid, busy, out_valid, out_data, out_id);
    end
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mptr = 0; last_data = '0; last_id = '0;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: %0d cycles with out_valid or busy high, required 0", bad);
    end
    rand_words();
    do_frame("post_reset", 4'b1111, 4'b0000, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] pat;
    int gap, bad;
    for (int f = 0; f < 24; f++) begin
      rand_words();
      pat = N'($urandom_range(1, 15));
      do_frame("random", pat, N'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      gap = $urandom_range(0, 2);
      bad = 0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        if (busy !== 1'b0 || out_valid !== 1'b0 || gnt !== '0) bad++;
      end
      if (gap > 0) begin
        tests_run++;
        if (bad != 0) begin
          fails++;
          $display("FAIL random_gap: %0d idle cycles not quiet, required 0", bad);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_req();
    test_wrap();
    test_drop();
    test_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sipo_rr_arbiter.md
# sipo_rr_arbiter

Arbiter that shares one 4-bit serial-to-parallel converter among several serial requesters. It grants one requester at a time using round-robin, steers that requester's bit stream into the shared converter for exactly one frame, and captures the parallel word. It then returns the word tagged with the source ID. It sits between the requester bank and the converter instance.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- FRAME_LEN, 4, bits per frame; must equal the converter's parallel width
- ID_W, $clog2(NUM_REQ), width of out_id

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  NUM_REQ  per-requester frame request, level
- s_data  input  NUM_REQ  per-requester serial bit, sampled only while that requester is granted
- gnt  output  NUM_REQ  one-hot grant, registered; high for exactly FRAME_LEN cycles per frame
- sipo_in_valid  output  1  to converter in_valid
- sipo_s_in  output  1  to converter s_in
- sipo_out_valid  input  1  from converter out_valid
- sipo_p_out  input  FRAME_LEN  from converter p_out
- out_valid  output  1  one-cycle pulse, tagged word available
- out_data  output  FRAME_LEN  captured word
- out_id  output  ID_W  index of the source requester
- busy  output  1  high in any state other than IDLE
- err  output  1  one-cycle pulse, converter did not answer

## Operation
- FSM states: IDLE, XFER, WAIT.
- IDLE:
  - If req is nonzero, select the winner, register gnt (one-hot) and sel_id, clear bit_cnt, and go to XFER.
  - Otherwise stay in IDLE.
- XFER:
  - sipo_in_valid = 1 and sipo_s_in = s_data[sel_id]. Both are combinational from registered state, so a requester's bit is consumed in the same cycle its gnt is high.
  - The first bit presented becomes the MSB of the word (the converter shifts left).
  - bit_cnt increments each cycle. When bit_cnt == FRAME_LEN-1: clear gnt, go to WAIT.
- WAIT (exactly one cycle):
  - If sipo_out_valid = 1: register out_data <= sipo_p_out, out_id <= sel_id, and out_valid <= 1.
  - Otherwise pulse err <= 1 and drop the word.
  - Always go to IDLE.
- Round-robin:
  - Pointer ptr is the search start. The winner is the first set req bit at index ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - On grant, ptr <= winner+1 mod NUM_REQ. Reset value of ptr is 0.
- A requester that drops req mid-frame is still clocked out for all FRAME_LEN cycles; the word is delivered regardless.
- req changes during XFER and WAIT are ignored until the next IDLE.
- sipo_in_valid is 0 in IDLE and WAIT. This keeps the converter counter realigned at every frame boundary.

## Timing
- Reset values: gnt=0, sipo_in_valid=0, sipo_s_in=0, out_valid=0, out_data=0, out_id=0, busy=0, err=0, state=IDLE, ptr=0, bit_cnt=0.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronous).
  - The partial frame is discarded and no out_valid is produced.
  - The converter also resets because it shares rst_n.
- Cycle timeline, with req seen in IDLE at cycle T:
  - T+1..T+FRAME_LEN: gnt and sipo_in_valid are high.
  - T+FRAME_LEN+1: WAIT; the converter's out_valid is expected here.
  - T+FRAME_LEN+2: out_valid high and state back in IDLE, where the next arbitration can occur.
- Minimum frame period is FRAME_LEN+2 cycles (6 cycles at defaults). Latency from req to out_valid is FRAME_LEN+2 cycles.
- out_data and out_id hold their value until the next capture. out_valid is a single-cycle pulse.
- Simultaneous requests: only one grant is issued per arbitration, and losers wait. No requester waits more than NUM_REQ-1 frames.

## Configuration
- SIPO_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, where the lowest set req index always wins. ptr is not implemented, and starvation of high indices is permitted.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset, then req=4'b0010 with requester 1 driving 1,0,1,1 → gnt=4'b0010 for 4 cycles; 6 cycles after req is sampled, out_valid=1, out_data=4'b1011, out_id=1.
- req=4'b1111 held constant for 8 frames → grant order 0,1,2,3,0,1,2,3; each out_id matches its grant; consecutive frames are 6 cycles apart.
- req=4'b1001 after requester 0 was last served → requester 3 is granted next, then requester 0 (wrap-around).
- Requester 2 drops req after the second bit of its frame → gnt is still held 4 cycles and the word is delivered with out_id=2.
- rst_n pulsed low during the third XFER cycle → gnt, sipo_in_valid and busy go to 0 immediately; no out_valid follows; the next frame after reset starts from requester 0.
- Converter stubbed to never raise out_valid → err pulses 1 cycle in WAIT, out_valid stays 0, and the FSM returns to IDLE. Build with SIPO_ARB_FIXED_PRIO_EN and req=4'b1111 → requester 0 is granted every frame.
